// File: rtl/vga_timing_gen_if.sv
// Pixel-side signal bundle of the raster timing generator: coordinates out,
// colour back in, and the blank-gated RGB/sync pins.
interface vga_timing_gen_if;
    logic [10:0] draw_x;
    logic [10:0] draw_y;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic        hsync;
    logic        vsync;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        active;
    logic        frame_tick;

    modport master (
        output draw_x, draw_y, hsync, vsync, r, g, b, active, frame_tick,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  draw_x, draw_y, hsync, vsync, r, g, b, active, frame_tick,
        output r_in, g_in, b_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, sync and blank
// decode, a short delay line matching the colour lookup latency, and a
// registered output stage for the RGB and sync pins.
module vga_timing_gen #(
    parameter int unsigned H_VIS    = 1280,
    parameter int unsigned H_FP     = 64,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 200,
    parameter int unsigned V_VIS    = 800,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 24,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 2
) (
    input logic               clk,
    input logic               rst,
    vga_timing_gen_if.master  vif
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // 12-bit bounds so that an end boundary equal to 2048 still compares correctly
    localparam logic [11:0] H_ACT_END = 12'(H_VIS);
    localparam logic [11:0] HS_START  = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_END = 12'(V_VIS);
    localparam logic [11:0] VS_START  = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_VIS + V_FP + V_SYNC);

    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [11:0] x_ext;
    logic [11:0] y_ext;

    logic        act_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  raw;
    logic [2:0]  dly;

    logic        hs_q;
    logic        vs_q;
    logic        act_q;
    logic [3:0]  r_q;
    logic [3:0]  g_q;
    logic [3:0]  b_q;
    logic        tick_q;

    // Pixel and line counters; both wrap on the same edge at end of frame
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == H_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == V_LAST) ? 11'd0 : y_cnt + 11'd1;
        end else begin
            x_cnt <= x_cnt + 11'd1;
        end
    end

    assign x_ext   = {1'b0, x_cnt};
    assign y_ext   = {1'b0, y_cnt};
    assign act_raw = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    assign hs_raw  = (x_ext >= HS_START) && (x_ext < HS_END);
    assign vs_raw  = (y_ext >= VS_START) && (y_ext < VS_END);
    assign raw     = {act_raw, hs_raw, vs_raw};

    // Delay the raw decode by PIPE_DLY-1 clocks so it meets the colour returned for the same pixel
    generate
        if (PIPE_DLY == 1) begin : g_no_dly
            assign dly = raw;
        end else begin : g_dly
            logic [2:0] sr [0:PIPE_DLY-2];

            // Shift register; reset clears every stage so no stale sync survives
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(PIPE_DLY) - 1; i++) begin
                        sr[i] <= 3'b000;
                    end
                end else begin
                    sr[0] <= raw;
                    for (int i = 1; i < int'(PIPE_DLY) - 1; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dly = sr[PIPE_DLY-2];
        end
    endgenerate

    // Output register: polarity-adjusted syncs, blank-gated colour, and the frame tick
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            act_q  <= 1'b0;
            r_q    <= 4'h0;
            g_q    <= 4'h0;
            b_q    <= 4'h0;
            tick_q <= 1'b0;
        end else begin
            hs_q   <= dly[1] ~^ HS_POL;
            vs_q   <= dly[0] ~^ VS_POL;
            act_q  <= dly[2];
            r_q    <= dly[2] ? vif.r_in : 4'h0;
            g_q    <= dly[2] ? vif.g_in : 4'h0;
            b_q    <= dly[2] ? vif.b_in : 4'h0;
            // Fires on the edge that wraps both counters, so it is high while they read (0,0)
            tick_q <= (x_cnt == H_LAST) && (y_cnt == V_LAST);
        end
    end

    assign vif.draw_x     = x_cnt;
    assign vif.draw_y     = y_cnt;
    assign vif.hsync      = hs_q;
    assign vif.vsync      = vs_q;
    assign vif.active     = act_q;
    assign vif.r          = r_q;
    assign vif.g          = g_q;
    assign vif.b          = b_q;
    assign vif.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32x16 clocks per frame)
// with three instances at PIPE_DLY = 1, 2 and 4.
module tb_vga_timing_gen;

    localparam int HV  = 16;
    localparam int HF  = 4;
    localparam int HSY = 6;
    localparam int HB  = 6;
    localparam int VV  = 10;
    localparam int VF  = 1;
    localparam int VSY = 3;
    localparam int VB  = 2;
    localparam int HT  = HV + HF + HSY + HB;   // 32
    localparam int VT  = VV + VF + VSY + VB;   // 16
    localparam int FT  = HT * VT;              // 512

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } px_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int c        = 0;
    int last_tick = -1;

    px_t q1[$];
    px_t q2[$];
    px_t q4[$];
    px_t e1, e2, e4;

    vga_timing_gen_if vif1();
    vga_timing_gen_if vif2();
    vga_timing_gen_if vif4();

    vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(1))
        dut1 (.clk(clk), .rst(rst), .vif(vif1));

    vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(2))
        dut2 (.clk(clk), .rst(rst), .vif(vif2));

    vga_timing_gen #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(4))
        dut4 (.clk(clk), .rst(rst), .vif(vif4));

    always #5 clk = ~clk;

    // Expected pin state for the pixel at a given coordinate index (negative = pipeline still empty)
    function automatic px_t model(input int coord);
        px_t p;
        int  pos, x, y;
        p = '0;
        p.hs = 1'b1;
        if (coord >= 0) begin
            pos   = coord % FT;
            x     = pos % HT;
            y     = pos / HT;
            p.act = (x < HV) && (y < VV);
            p.hs  = !((x >= HV + HF) && (x < HV + HF + HSY));
            p.vs  = (y >= VV + VF) && (y < VV + VF + VSY);
            p.r   = p.act ? 4'(x) : 4'h0;
            p.g   = p.act ? 4'(y) : 4'h0;
            p.b   = p.act ? ~4'(x) : 4'h0;
        end
        return p;
    endfunction

    // Colour the bench returns for a coordinate: the pattern when visible, all-ones in blanking
    function automatic logic [11:0] in_rgb(input int coord);
        px_t m;
        m = model(coord);
        return m.act ? {m.r, m.g, m.b} : 12'hfff;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_px(input string tag, input px_t got, input px_t e);
        chk({tag, ".active"}, int'(got.act), int'(e.act));
        chk({tag, ".hsync"},  int'(got.hs),  int'(e.hs));
        chk({tag, ".vsync"},  int'(got.vs),  int'(e.vs));
        chk({tag, ".r"},      int'(got.r),   int'(e.r));
        chk({tag, ".g"},      int'(got.g),   int'(e.g));
        chk({tag, ".b"},      int'(got.b),   int'(e.b));
    endtask

    // Scoreboard monitor: one output pixel per clock once each pipeline is primed, idle pins before that
    always @(posedge clk) begin
        #1;
        e1 = (q1.size() >= 1) ? q1.pop_front() : model(-1);
        e2 = (q2.size() >= 2) ? q2.pop_front() : model(-1);
        e4 = (q4.size() >= 4) ? q4.pop_front() : model(-1);
        chk_px("p1", {vif1.active, vif1.hsync, vif1.vsync, vif1.r, vif1.g, vif1.b}, e1);
        chk_px("p2", {vif2.active, vif2.hsync, vif2.vsync, vif2.r, vif2.g, vif2.b}, e2);
        chk_px("p4", {vif4.active, vif4.hsync, vif4.vsync, vif4.r, vif4.g, vif4.b}, e4);
    end

    // One clock of stimulus, called at the falling edge of clock c after reset release
    task automatic step();
        int pos;
        pos = c % FT;
        chk("draw_x", int'(vif2.draw_x), pos % HT);
        chk("draw_y", int'(vif2.draw_y), pos / HT);
        chk("frame_tick", int'(vif2.frame_tick), (pos == 0 && c > 0) ? 1 : 0);
        chk("frame_tick_p4", int'(vif4.frame_tick), (pos == 0 && c > 0) ? 1 : 0);
        if (vif2.frame_tick) begin
            if (last_tick >= 0) chk("tick_spacing", c - last_tick, FT);
            last_tick = c;
        end
        {vif1.r_in, vif1.g_in, vif1.b_in} = in_rgb(c);
        {vif2.r_in, vif2.g_in, vif2.b_in} = in_rgb(c - 1);
        {vif4.r_in, vif4.g_in, vif4.b_in} = in_rgb(c - 3);
        q1.push_back(model(c));
        q2.push_back(model(c));
        q4.push_back(model(c));
        @(negedge clk);
        c++;
    endtask

    initial begin
        {vif1.r_in, vif1.g_in, vif1.b_in} = 12'hfff;
        {vif2.r_in, vif2.g_in, vif2.b_in} = 12'hfff;
        {vif4.r_in, vif4.g_in, vif4.b_in} = 12'hfff;
        rst = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk("rst_draw_x", int'(vif2.draw_x), 0);
            chk("rst_draw_y", int'(vif2.draw_y), 0);
            chk("rst_frame_tick", int'(vif2.frame_tick), 0);
        end

        rst = 1'b0;
        c = 0;
        last_tick = -1;
        // Two full frames, then stop mid-vsync at line 12, pixel 10
        repeat (2 * FT + 12 * HT + 10) step();

        chk("pre_rst_vsync", int'(vif2.vsync), 1);
        rst = 1'b1;
        q1.delete();
        q2.delete();
        q4.delete();
        @(negedge clk);
        chk("mid_rst_vsync", int'(vif2.vsync), 0);
        chk("mid_rst_hsync", int'(vif2.hsync), 1);
        chk("mid_rst_active", int'(vif2.active), 0);
        chk("mid_rst_draw_x", int'(vif2.draw_x), 0);
        chk("mid_rst_draw_y", int'(vif2.draw_y), 0);
        chk("mid_rst_vsync_p4", int'(vif4.vsync), 0);

        rst = 1'b0;
        c = 0;
        last_tick = -1;
        repeat (2 * FT + 40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
